// File: rtl/a_unit_pkg.sv
// Shared constants and opcode decode for the address-unit issue and writeback slice.
package a_unit_pkg;

    localparam int W       = 24;
    localparam int NREG    = 8;
    localparam int IDX_W   = 3;
    localparam int ADD_LAT = 2;
    localparam int MUL_LAT = 6;

    localparam logic [6:0] OP_AADD = 7'o030;
    localparam logic [6:0] OP_ASUB = 7'o031;
    localparam logic [6:0] OP_AMUL = 7'o032;

    function automatic logic is_addr_op(input logic [6:0] op);
        logic r;
        case (op)
            OP_AADD, OP_ASUB, OP_AMUL: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/a_result_wb_if.sv
// Issue-side request/response and unit-result writeback signals of the A-register block.
interface a_result_wb_if #(
    parameter int W  = 24,
    parameter int IW = 3
);
    logic          i_issue;
    logic [6:0]    i_instr;
    logic [IW-1:0] i_i;
    logic [IW-1:0] i_j;
    logic [IW-1:0] i_k;
    logic          o_hold;
    logic [W-1:0]  o_aj;
    logic [W-1:0]  o_ak;
    logic          o_accept;
    logic [W-1:0]  i_add_result;
    logic [W-1:0]  i_mul_result;
    logic          o_wr_en;
    logic [IW-1:0] o_wr_addr;
    logic [W-1:0]  o_wr_data;

    modport master (
        output i_issue, i_instr, i_i, i_j, i_k, i_add_result, i_mul_result,
        input  o_hold, o_aj, o_ak, o_accept, o_wr_en, o_wr_addr, o_wr_data
    );

    modport slave (
        input  i_issue, i_instr, i_i, i_j, i_k, i_add_result, i_mul_result,
        output o_hold, o_aj, o_ak, o_accept, o_wr_en, o_wr_addr, o_wr_data
    );
endinterface

// File: rtl/a_result_wb_tag_pipe.sv
// Destination-tag shift register: a tag loaded on an edge reaches stage 0 DEPTH cycles later.
module tag_pipe #(
    parameter int DEPTH = 2,
    parameter int AW    = 3,
    parameter int PEEK  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic [AW-1:0] load_dest,
    output logic          out_valid,
    output logic [AW-1:0] out_dest,
    output logic          peek_valid
);

    logic [DEPTH-1:0]         valid_q, valid_d;
    logic [DEPTH-1:0][AW-1:0] dest_q,  dest_d;

    // shift toward stage 0, new tag enters at the top stage
    always_comb begin
        valid_d = {load_en, valid_q[DEPTH-1:1]};
        dest_d  = {(load_en ? load_dest : {AW{1'b0}}), dest_q[DEPTH-1:1]};
    end

    // tag state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= {DEPTH{1'b0}};
            dest_q  <= {(DEPTH*AW){1'b0}};
        end else begin
            valid_q <= valid_d;
            dest_q  <= dest_d;
        end
    end

    assign out_valid  = valid_q[0];
    assign out_dest   = dest_q[0];
    assign peek_valid = valid_q[PEEK];

endmodule

// File: rtl/a_result_wb.sv
// A-register file with reservation bits, result-bus collision check and unit-result writeback.
module a_result_wb
    import a_unit_pkg::*;
#(
    parameter int W       = a_unit_pkg::W,
    parameter int NREG    = a_unit_pkg::NREG,
    parameter int ADD_LAT = a_unit_pkg::ADD_LAT,
    parameter int MUL_LAT = a_unit_pkg::MUL_LAT
) (
    input  logic          clk,
    input  logic          rst,
    a_result_wb_if.slave  bus
);

    localparam int IW = $clog2(NREG);

    logic [NREG-1:0][W-1:0] a_q, a_d;
    logic [NREG-1:0]        res_q, res_d;

    logic          is_addr_s, is_mul_s, conflict_s, collide_s, hold_s, accept_s;
    logic          add_v0_s, mul_v0_s, mul_peek_s, add_peek_unused_s;
    logic [IW-1:0] add_dest_s, mul_dest_s;
    logic          wr_en_s;
    logic [IW-1:0] wr_addr_s;
    logic [W-1:0]  wr_data_s;

    // issue decode; a 030/031 may not land on the same cycle as an older 032
    always_comb begin
        is_addr_s  = is_addr_op(bus.i_instr);
        is_mul_s   = (bus.i_instr == OP_AMUL);
        conflict_s = res_q[bus.i_i]
                   | ((bus.i_j != {IW{1'b0}}) & res_q[bus.i_j])
                   | ((bus.i_k != {IW{1'b0}}) & res_q[bus.i_k]);
        collide_s  = ~is_mul_s & mul_peek_s;
        hold_s     = ~rst & bus.i_issue & is_addr_s & (conflict_s | collide_s);
        accept_s   = ~rst & bus.i_issue & is_addr_s & ~(conflict_s | collide_s);
    end

    // operand read; A0 reads as 0 for Aj and 1 for Ak
    always_comb begin
        if (rst || (bus.i_j == {IW{1'b0}})) begin
            bus.o_aj = {W{1'b0}};
        end else begin
            bus.o_aj = a_q[bus.i_j];
        end
        if (bus.i_k == {IW{1'b0}}) begin
            bus.o_ak = {{(W-1){1'b0}}, 1'b1};
        end else if (rst) begin
            bus.o_ak = {W{1'b0}};
        end else begin
            bus.o_ak = a_q[bus.i_k];
        end
    end

    // result-bus writeback select
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = {IW{1'b0}};
        wr_data_s = {W{1'b0}};
        if (rst) begin
            wr_en_s = 1'b0;
        end else if (add_v0_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = add_dest_s;
            wr_data_s = bus.i_add_result;
        end else if (mul_v0_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = mul_dest_s;
            wr_data_s = bus.i_mul_result;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // register file and reservation next state
    always_comb begin
        a_d   = a_q;
        res_d = res_q;
        if (wr_en_s) begin
            a_d[wr_addr_s]   = wr_data_s;
            res_d[wr_addr_s] = 1'b0;
        end else begin
            a_d = a_q;
        end
        if (accept_s) begin
            res_d[bus.i_i] = 1'b1;
        end else begin
            res_d = res_d;
        end
    end

    // architectural state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= {(NREG*W){1'b0}};
            res_q <= {NREG{1'b0}};
        end else begin
            a_q   <= a_d;
            res_q <= res_d;
        end
    end

    tag_pipe #(.DEPTH(ADD_LAT), .AW(IW), .PEEK(0)) u_add_pipe (
        .clk        (clk),
        .rst        (rst),
        .load_en    (accept_s & ~is_mul_s),
        .load_dest  (bus.i_i),
        .out_valid  (add_v0_s),
        .out_dest   (add_dest_s),
        .peek_valid (add_peek_unused_s)
    );

    tag_pipe #(.DEPTH(MUL_LAT), .AW(IW), .PEEK(ADD_LAT)) u_mul_pipe (
        .clk        (clk),
        .rst        (rst),
        .load_en    (accept_s & is_mul_s),
        .load_dest  (bus.i_i),
        .out_valid  (mul_v0_s),
        .out_dest   (mul_dest_s),
        .peek_valid (mul_peek_s)
    );

    assign bus.o_hold    = hold_s;
    assign bus.o_accept  = accept_s;
    assign bus.o_wr_en   = wr_en_s;
    assign bus.o_wr_addr = wr_addr_s;
    assign bus.o_wr_data = wr_data_s;

endmodule

// File: tb/tb_a_result_wb.sv
// Bench for a_result_wb: directed scenarios plus randomized issue against a landing-time model.
module tb_a_result_wb;
    import a_unit_pkg::*;

    typedef struct { int land; logic [IDX_W-1:0] dest; bit mul; } tag_t;

    logic clk;
    logic rst;

    a_result_wb_if #(.W(W), .IW(IDX_W)) bus ();

    a_result_wb #(.W(W), .NREG(NREG), .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: register values, reserved set, and the list of results still to land.
    logic [W-1:0]     a_m [NREG];
    bit   [NREG-1:0]  res_m;
    tag_t             inflight [$];

    logic             e_hold, e_accept, e_wr_en;
    logic [IDX_W-1:0] e_wr_addr;
    logic [W-1:0]     e_aj, e_ak, e_wr_data;
    bit               e_mul;
    int               wb_idx;

    task automatic model_clear();
        foreach (a_m[r]) a_m[r] = '0;
        res_m = '0;
        inflight.delete();
    endtask

    task automatic drive(input bit issue, input logic [6:0] op,
                         input logic [IDX_W-1:0] ii, input logic [IDX_W-1:0] jj,
                         input logic [IDX_W-1:0] kk, input logic [W-1:0] ar,
                         input logic [W-1:0] mr);
        bit addr_op, conflict, collide;
        int lat;
        bus.i_issue = issue; bus.i_instr = op;
        bus.i_i = ii; bus.i_j = jj; bus.i_k = kk;
        bus.i_add_result = ar; bus.i_mul_result = mr;
        e_mul    = (op == OP_AMUL);
        lat      = e_mul ? MUL_LAT : ADD_LAT;
        addr_op  = (op == OP_AADD) || (op == OP_ASUB) || (op == OP_AMUL);
        conflict = res_m[ii] || (jj != 0 && res_m[jj]) || (kk != 0 && res_m[kk]);
        collide  = 0;
        wb_idx   = -1;
        foreach (inflight[q]) begin
            if (inflight[q].land == cyc + lat) collide = 1;
            if (inflight[q].land == cyc) wb_idx = q;
        end
        e_aj      = (jj == 0) ? W'(0) : a_m[jj];
        e_ak      = (kk == 0) ? W'(1) : a_m[kk];
        e_hold    = issue && addr_op && (conflict || collide);
        e_accept  = issue && addr_op && !e_hold;
        e_wr_en   = (wb_idx >= 0);
        e_wr_addr = '0;
        e_wr_data = '0;
        if (wb_idx >= 0) begin
            e_wr_addr = inflight[wb_idx].dest;
            e_wr_data = inflight[wb_idx].mul ? mr : ar;
        end
        if (rst) begin
            e_aj = '0; e_ak = (kk == 0) ? W'(1) : W'(0);
            e_hold = 0; e_accept = 0; e_wr_en = 0; e_wr_addr = '0; e_wr_data = '0;
        end
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            if (e_wr_en) begin
                a_m[e_wr_addr] = e_wr_data;
                res_m[e_wr_addr] = 0;
                inflight.delete(wb_idx);
            end
            if (e_accept) begin
                res_m[bus.i_i] = 1;
                inflight.push_back('{cyc + (e_mul ? MUL_LAT : ADD_LAT), bus.i_i, e_mul});
            end
        end
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            drive(0, 7'o000, 0, 0, 0, W'($urandom), W'($urandom));
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1, OP_AADD, 1, 2, 3, W'($urandom), W'($urandom));
        checks++; if (bus.o_hold !== 1'b0 || bus.o_accept !== 1'b0) begin failures++; $display("FAIL reset_hold_accept got %b%b want 00", bus.o_hold, bus.o_accept); end
        checks++; if (bus.o_wr_en !== 1'b0 || bus.o_wr_addr !== 3'd0 || bus.o_wr_data !== 24'd0) begin failures++; $display("FAIL reset_wr got %b %0d %h want 0 0 0", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        checks++; if (bus.o_aj !== 24'd0 || bus.o_ak !== 24'd0) begin failures++; $display("FAIL reset_operands got %h %h want 0 0", bus.o_aj, bus.o_ak); end
        tick();
        drive(1, OP_AADD, 1, 2, 0, W'($urandom), W'($urandom));
        checks++; if (bus.o_ak !== 24'd1) begin failures++; $display("FAIL reset_ak_k0 got %h want 1", bus.o_ak); end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_add_basic();
        drive(1, OP_AADD, 1, 0, 0, 0, 0);
        checks++; if (bus.o_aj !== 24'd0 || bus.o_ak !== 24'd1 || bus.o_accept !== 1'b1) begin failures++; $display("FAIL add_issue got aj=%h ak=%h acc=%b want 0 1 1", bus.o_aj, bus.o_ak, bus.o_accept); end
        tick();
        drive(0, 7'o000, 0, 0, 0, 24'd9, 0);
        checks++; if (bus.o_wr_en !== 1'b0) begin failures++; $display("FAIL add_early_wr got %b want 0", bus.o_wr_en); end
        tick();
        drive(0, 7'o000, 0, 0, 0, 24'd1, 0);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 3'd1 || bus.o_wr_data !== 24'd1) begin failures++; $display("FAIL add_wb got %b %0d %h want 1 1 1", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tick();
        drive(0, 7'o000, 0, 1, 0, 0, 0);
        checks++; if (bus.o_aj !== 24'd1) begin failures++; $display("FAIL add_a1 got %h want 1", bus.o_aj); end
        tick();
    endtask

    task automatic test_reservation();
        drive(1, OP_AADD, 2, 0, 0, 0, 0); tick();
        drive(1, OP_AADD, 3, 0, 0, 0, 0); tick();
        drive(0, 7'o000, 0, 0, 0, 24'd5, 0); tick();
        drive(0, 7'o000, 0, 0, 0, 24'd3, 0); tick();
        drive(1, OP_ASUB, 4, 2, 3, 0, 0);
        checks++; if (bus.o_accept !== 1'b1 || bus.o_aj !== 24'd5 || bus.o_ak !== 24'd3) begin failures++; $display("FAIL res_sub got acc=%b aj=%h ak=%h want 1 5 3", bus.o_accept, bus.o_aj, bus.o_ak); end
        tick();
        drive(1, OP_AADD, 6, 4, 0, 0, 0);
        checks++; if (bus.o_hold !== 1'b1 || bus.o_accept !== 1'b0) begin failures++; $display("FAIL res_hold1 got %b%b want 10", bus.o_hold, bus.o_accept); end
        tick();
        drive(1, OP_AADD, 6, 4, 0, 24'd2, 0);
        checks++; if (bus.o_hold !== 1'b1) begin failures++; $display("FAIL res_hold2 got %b want 1", bus.o_hold); end
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 3'd4 || bus.o_wr_data !== 24'd2) begin failures++; $display("FAIL res_wb got %b %0d %h want 1 4 2", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tick();
        drive(1, OP_AADD, 6, 4, 0, 0, 0);
        checks++; if (bus.o_accept !== 1'b1 || bus.o_aj !== 24'd2) begin failures++; $display("FAIL res_release got acc=%b aj=%h want 1 2", bus.o_accept, bus.o_aj); end
        tick();
        idle(4);
    endtask

    task automatic test_collision();
        drive(1, OP_AMUL, 5, 0, 0, 0, 0);
        checks++; if (bus.o_accept !== 1'b1) begin failures++; $display("FAIL col_mul_acc got %b want 1", bus.o_accept); end
        tick();
        for (int n = 0; n < 3; n++) begin
            drive(0, 7'o000, 0, 0, 0, W'($urandom), W'($urandom));
            checks++; if (bus.o_wr_en !== 1'b0) begin failures++; $display("FAIL col_quiet got %b want 0", bus.o_wr_en); end
            tick();
        end
        drive(1, OP_AADD, 6, 0, 0, 0, 0);
        checks++; if (bus.o_hold !== 1'b1 || bus.o_accept !== 1'b0) begin failures++; $display("FAIL col_hold got %b%b want 10", bus.o_hold, bus.o_accept); end
        tick();
        drive(1, OP_AADD, 6, 0, 0, 0, 0);
        checks++; if (bus.o_hold !== 1'b0 || bus.o_accept !== 1'b1) begin failures++; $display("FAIL col_retry got %b%b want 01", bus.o_hold, bus.o_accept); end
        tick();
        drive(0, 7'o000, 0, 0, 0, 24'd1, 24'd77);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 3'd5 || bus.o_wr_data !== 24'd77) begin failures++; $display("FAIL col_wb_mul got %b %0d %h want 1 5 4d", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tick();
        drive(0, 7'o000, 0, 0, 0, 24'd88, 24'd2);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 3'd6 || bus.o_wr_data !== 24'd88) begin failures++; $display("FAIL col_wb_add got %b %0d %h want 1 6 58", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1, OP_AADD, 1, 2, 3, 0, 0);
        checks++; if (bus.o_accept !== 1'b1) begin failures++; $display("FAIL b2b_first got %b want 1", bus.o_accept); end
        tick();
        drive(1, OP_AADD, 2, 3, 0, 0, 0);
        checks++; if (bus.o_accept !== 1'b1) begin failures++; $display("FAIL b2b_second got %b want 1", bus.o_accept); end
        tick();
        drive(0, 7'o000, 0, 0, 0, 24'd11, 0);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 3'd1 || bus.o_wr_data !== 24'd11) begin failures++; $display("FAIL b2b_wb1 got %b %0d %h want 1 1 b", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tick();
        drive(0, 7'o000, 0, 0, 0, 24'hFFFFFF, 0);
        checks++; if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 3'd2 || bus.o_wr_data !== 24'hFFFFFF) begin failures++; $display("FAIL b2b_wb2 got %b %0d %h want 1 2 ffffff", bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data); end
        tick();
        drive(0, 7'o000, 0, 1, 2, 0, 0);
        checks++; if (bus.o_aj !== 24'd11 || bus.o_ak !== 24'hFFFFFF) begin failures++; $display("FAIL b2b_regs got %h %h want b ffffff", bus.o_aj, bus.o_ak); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1, OP_AMUL, 7, 0, 0, 0, 0); tick();
        drive(0, 7'o000, 0, 0, 0, 0, 0); tick();
        drive(0, 7'o000, 0, 0, 0, 0, 0); tick();
        rst = 1'b1;
        drive(1, OP_AADD, 1, 0, 0, 0, 24'hABCDEF);
        checks++; if (bus.o_accept !== 1'b0 || bus.o_hold !== 1'b0) begin failures++; $display("FAIL rstmid_gate got %b%b want 00", bus.o_accept, bus.o_hold); end
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(0, 7'o000, 0, 0, 0, 0, 24'hABCDEF);
            checks++; if (bus.o_wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_no_wb got %b want 0", bus.o_wr_en); end
            tick();
        end
        drive(1, OP_AADD, 1, 7, 0, 0, 0);
        checks++; if (bus.o_accept !== 1'b1 || bus.o_aj !== 24'd0) begin failures++; $display("FAIL rstmid_a7 got acc=%b aj=%h want 1 0", bus.o_accept, bus.o_aj); end
        tick();
        idle(3);
    endtask

    task automatic test_non_addr();
        drive(1, 7'o020, 1, 2, 3, 0, 0);
        checks++; if (bus.o_accept !== 1'b0 || bus.o_hold !== 1'b0) begin failures++; $display("FAIL nonaddr got %b%b want 00", bus.o_accept, bus.o_hold); end
        tick();
        drive(1, OP_AADD, 1, 1, 0, 0, 0);
        checks++; if (bus.o_accept !== e_accept || bus.o_aj !== e_aj) begin failures++; $display("FAIL nonaddr_state got acc=%b aj=%h want %b %h", bus.o_accept, bus.o_aj, e_accept, e_aj); end
        tick();
        idle(3);
    endtask

    task automatic test_random();
        logic [6:0] op;
        int sel;
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            sel = $urandom_range(0, 7);
            op  = (sel < 3) ? OP_AADD : (sel < 5) ? OP_ASUB : (sel < 7) ? OP_AMUL : 7'($urandom_range(0, 127));
            drive($urandom_range(0, 3) != 0, op, 3'($urandom), 3'($urandom), 3'($urandom),
                  W'($urandom), W'($urandom));
            checks++; if (bus.o_aj !== e_aj) begin failures++; $display("FAIL rnd_aj cyc=%0d got %h want %h", cyc, bus.o_aj, e_aj); end
            checks++; if (bus.o_ak !== e_ak) begin failures++; $display("FAIL rnd_ak cyc=%0d got %h want %h", cyc, bus.o_ak, e_ak); end
            checks++; if (bus.o_hold !== e_hold) begin failures++; $display("FAIL rnd_hold cyc=%0d got %b want %b", cyc, bus.o_hold, e_hold); end
            checks++; if (bus.o_accept !== e_accept) begin failures++; $display("FAIL rnd_accept cyc=%0d got %b want %b", cyc, bus.o_accept, e_accept); end
            checks++; if (bus.o_wr_en !== e_wr_en) begin failures++; $display("FAIL rnd_wr_en cyc=%0d got %b want %b", cyc, bus.o_wr_en, e_wr_en); end
            checks++; if (bus.o_wr_addr !== e_wr_addr) begin failures++; $display("FAIL rnd_wr_addr cyc=%0d got %0d want %0d", cyc, bus.o_wr_addr, e_wr_addr); end
            checks++; if (bus.o_wr_data !== e_wr_data) begin failures++; $display("FAIL rnd_wr_data cyc=%0d got %h want %h", cyc, bus.o_wr_data, e_wr_data); end
            tick();
        end
        rst = 1'b0;
        idle(8);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_issue = 1'b0; bus.i_instr = 7'o000;
        bus.i_i = '0; bus.i_j = '0; bus.i_k = '0;
        bus.i_add_result = '0; bus.i_mul_result = '0;
        model_clear();
        test_reset();
        test_add_basic();
        test_reservation();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        test_non_addr();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/a_result_wb.md
Name: a_result_wb

Overview:
- Issue-side A-register file, reservation logic and result writeback for the address functional units.
- Sources Aj/Ak operands for 030/031 (address add/subtract) and 032 (address multiply).
- Tracks each in-flight destination Ai through a fixed-latency tag pipeline and writes the returning unit result into Ai.
- Holds issue on any register reservation or result-bus collision.
- Sits upstream of the address add and address multiply units (feeds their operands) and downstream of them (consumes their results).

Parameters:
- W, 24, A-register / operand width
- NREG, 8, number of A registers (index width 3)
- ADD_LAT, 2, address add unit latency, operand cycle to result-valid cycle
- MUL_LAT, 6, address multiply unit latency, same definition; must exceed ADD_LAT

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_issue  in  1  instruction presented this cycle
- i_instr  in  7  opcode (7'o030 add, 7'o031 sub, 7'o032 mul)
- i_i  in  3  destination register index
- i_j  in  3  first operand register index
- i_k  in  3  second operand register index
- o_hold  out  1  issue blocked this cycle (combinational)
- o_aj  out  W  Aj operand to units (combinational)
- o_ak  out  W  Ak operand to units (combinational)
- o_accept  out  1  instruction accepted this cycle
- i_add_result  in  W  address add unit result
- i_mul_result  in  W  address multiply unit result
- o_wr_en  out  1  A-register write this cycle
- o_wr_addr  out  3  register written
- o_wr_data  out  W  value written

Behaviour:
- Opcode classes:
  - addr_op = 030, 031 or 032.
  - Any other opcode: o_accept=0, no state change, o_hold=0.
- Operand read:
  - o_aj = 0 when j==0, else A[j].
  - o_ak = 1 when k==0, else A[k].
  - Both are driven regardless of i_issue.
- Reservations:
  - res[NREG-1:0] holds one bit per register.
  - A conflict exists when res[i], or res[j] with j!=0, or res[k] with k!=0.
- Bus collision:
  - add_pipe and mul_pipe are tag shift registers; stage s holds {valid, dest} landing s cycles from now.
  - A 030/031 collides if mul_pipe stage ADD_LAT is valid.
  - A 032 never collides.
- o_hold = i_issue & addr_op & (reservation conflict | collision).
- o_accept = i_issue & addr_op & ~o_hold.
- On an accept at cycle t:
  - Set res[i] at the edge ending cycle t.
  - Load {1,i} into stage LAT of the selected pipe.
- Every cycle both pipes shift down one stage.
- Stage 0 valid means the unit result is valid this cycle:
  - o_wr_en=1, o_wr_addr=dest.
  - o_wr_data = i_add_result or i_mul_result.
  - A[dest] and res[dest] clear are written at the edge ending this cycle.
- Timing consequences:
  - Issue at t writes Ai at the end of cycle t+LAT.
  - A dependent instruction issues no earlier than t+LAT+1.
- Simultaneous events:
  - Writeback and a new accept targeting the same register cannot occur, because res[i] holds issue until the writeback edge.
  - Writeback of register x and accept setting res[y] in the same cycle are independent.
  - At most one stage-0 valid per cycle is guaranteed by the collision rule.
- Writes to A0 are allowed and stored; A0 is just never read as an operand.
- Reset:
  - A[*]=0, res=0, both pipes invalid.
  - Outputs during and after reset: o_wr_en=0, o_wr_addr=0, o_wr_data=0, o_accept=0, o_hold=0, o_aj=0, o_ak=0 (o_ak=1 when i_k==0).
  - Reset mid-operation discards every in-flight tag; later unit results are ignored.
- No overflow detection; results are written modulo 2^W.

Decomposition:
- Package a_unit_pkg: opcode constants OP_AADD=7'o030, OP_ASUB=7'o031, OP_AMUL=7'o032; W, NREG, ADD_LAT, MUL_LAT defaults; register index width.
- Sub-module tag_pipe (params DEPTH, AW): valid+dest shift register with load-at-stage-DEPTH, peek of any stage, stage-0 output. Instantiated twice (add, mul).

Test Plan:
- Reset, then 030 i=1 j=0 k=0 at t → o_aj=0, o_ak=1, o_accept=1.
  - Drive i_add_result=1 at t+2 → o_wr_en=1, addr=1, data=1; A1=1 from t+3.
- A2=5, A3=3; 031 i=4 j=2 k=3 at t → o_accept=1, res[4]=1.
  - 030 with j=4 at t+1 and t+2 → o_hold=1 both cycles.
  - Same 030 at t+3 → accepted, o_aj=A4.
- 032 i=5 at t; 030 i=6 at t+4 → o_hold=1 (collision at t+6); retry at t+5 → accepted.
  - Writebacks occur at t+6 (reg 5) and t+7 (reg 6).
- Back-to-back 030 i=1, then 030 i=2 with independent operands → both accepted consecutively; writebacks at t+2 and t+3.
- 032 i=7 in flight, rst at t+3 → res cleared, no o_wr_en at t+6, A7 stays 0.
- Non-address opcode 7'o020 with i_issue=1 → o_accept=0, o_hold=0, no state change.
